// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: access sizes, port ids,
// the captured command record and the access legality rule.
package dmem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [2:0] FUNCT_BYTE = 3'b000;
    localparam logic [2:0] FUNCT_WORD = 3'b010;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [2:0]        funct;
        logic              err;
        logic              port;
    } cmd_t;

    // Only byte and aligned word accesses may reach the memory.
    function automatic logic is_illegal(input logic [2:0] funct, input logic [1:0] addr_lo);
        return !((funct == FUNCT_BYTE) || (funct == FUNCT_WORD)) ||
               ((funct == FUNCT_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_arb_if.sv
// Request/response bundle between the two requesters and the arbiter.
// The slave modport is the arbiter side, the master modport the requester side.
interface dmem_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);

    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0]            req_we;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [DATA_WIDTH-1:0] req_wdata0;
    logic [DATA_WIDTH-1:0] req_wdata1;
    logic [2:0]            req_funct0;
    logic [2:0]            req_funct1;
    logic [1:0]            rsp_valid;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1,
               req_wdata0, req_wdata1, req_funct0, req_funct1,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport master (
        output req_valid, req_we, req_addr0, req_addr1,
               req_wdata0, req_wdata1, req_funct0, req_funct1,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

endinterface

// File: rtl/dmem_arb_grant.sv
// Two-port grant logic. DMEM_ARB_RR_EN defined: round-robin on the last granted port;
// undefined: fixed priority to port 0 with no pointer register.
module dmem_arb_grant (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

`ifdef DMEM_ARB_RR_EN
    logic last_port;

    // Reset to "port 1 granted last" so that port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_port <= 1'b1;
        end else if (|grant) begin
            last_port <= grant[1];
        end
    end

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (valid == 2'b11) begin
                grant = last_port ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end
`else
    logic unused_clk;
    assign unused_clk = clk;

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            grant[0] = valid[0];
            grant[1] = valid[1] && !valid[0];
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester sequencer for the single-port data memory: accept, issue, respond.
// Arbitration policy selected by DMEM_ARB_RR_EN (round-robin) or fixed priority when undefined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_arb_if.slave             bus,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [2:0]            mem_funct,
    output logic [6:0]            mem_funct7,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    logic [1:0]            grant;
    cmd_t                  next_cmd;
    cmd_t                  cmd;
    logic                  cmd_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic [1:0]            rsp_valid_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    dmem_arb_grant u_grant (
        .clk   (clk),
        .reset (reset),
        .valid (bus.req_valid),
        .grant (grant)
    );

    assign bus.req_ready = grant;

    // The legality check is folded into the command at capture time.
    always_comb begin
        next_cmd = '0;
        if (grant[1]) begin
            next_cmd.port  = PORT_DMA;
            next_cmd.we    = bus.req_we[1];
            next_cmd.addr  = bus.req_addr1;
            next_cmd.wdata = bus.req_wdata1;
            next_cmd.funct = bus.req_funct1;
        end else begin
            next_cmd.port  = PORT_CORE;
            next_cmd.we    = bus.req_we[0];
            next_cmd.addr  = bus.req_addr0;
            next_cmd.wdata = bus.req_wdata0;
            next_cmd.funct = bus.req_funct0;
        end
        next_cmd.err = is_illegal(next_cmd.funct, next_cmd.addr[1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            cmd       <= '0;
        end else begin
            cmd_valid <= |grant;
            if (|grant) begin
                cmd <= next_cmd;
            end
        end
    end

    // The write enable is also gated by reset so a command caught by reset never writes.
    always_comb begin
        mem_wr_en   = cmd_valid && cmd.we && !cmd.err && !reset;
        mem_addr    = cmd_valid ? cmd.addr  : '0;
        mem_wr_data = cmd_valid ? cmd.wdata : '0;
        mem_funct   = cmd_valid ? cmd.funct : 3'b000;
    end

    assign mem_funct7 = 7'b0;

    always_comb begin
        load_data = '0;
        if (cmd_valid && !cmd.we && !cmd.err) begin
            if (cmd.funct == FUNCT_BYTE) begin
                load_data = {{(DATA_WIDTH-8){1'b0}}, mem_rd_data[7:0]};
            end else begin
                load_data = mem_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= cmd_valid ? (cmd.port ? 2'b10 : 2'b01) : 2'b00;
            rsp_err_q   <= cmd_valid && cmd.err;
            rsp_rdata_q <= load_data;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: requests are queued at acceptance and a monitor
// checks each response against a sequential reference memory (DMEM_ARB_RR_EN aware).
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int DW        = 32;
    localparam int AW        = 32;
    localparam int MEM_BYTES = 64;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [2:0]    funct;
    } req_t;

    typedef struct {
        req_t r;
        int   port;
        int   acc;
    } sb_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic [2:0]    mem_funct;
    logic [6:0]    mem_funct7;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_funct   (mem_funct),
        .mem_funct7  (mem_funct7),
        .mem_rd_data (mem_rd_data)
    );

    logic [7:0] phys_mem [MEM_BYTES];
    logic [7:0] ref_mem  [MEM_BYTES];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   gap_pct  = 0;
    int   wr_seen  = 0;
    int   wr_exp   = 0;
    logic exp_last = 1'b1;
    bit   pres [2];
    req_t cur  [2];
    req_t pq0 [$];
    req_t pq1 [$];
    sb_t  sb  [$];

    // Behavioural single-port memory driven by the DUT.
    always @(posedge clk) begin
        if (mem_wr_en) begin
            if (mem_funct == 3'b010) begin
                for (int b = 0; b < 4; b++) begin
                    phys_mem[int'(mem_addr[5:2]) * 4 + b] <= mem_wr_data[8*b +: 8];
                end
            end else begin
                phys_mem[int'(mem_addr[5:0])] <= mem_wr_data[7:0];
            end
        end
    end

    always_comb begin
        if (mem_funct == 3'b010) begin
            mem_rd_data = {phys_mem[int'(mem_addr[5:2]) * 4 + 3], phys_mem[int'(mem_addr[5:2]) * 4 + 2],
                           phys_mem[int'(mem_addr[5:2]) * 4 + 1], phys_mem[int'(mem_addr[5:2]) * 4]};
        end else begin
            mem_rd_data = {24'b0, phys_mem[int'(mem_addr[5:0])]};
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic ref_illegal(input logic [2:0] f, input logic [AW-1:0] a);
        return !(f == 3'b000 || f == 3'b010) || (f == 3'b010 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a, input logic [2:0] f);
        int b;
        b = int'(a[5:2]) * 4;
        if (f == 3'b010) return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
        return {24'b0, ref_mem[int'(a[5:0])]};
    endfunction

    task automatic ref_write(input logic [AW-1:0] a, input logic [2:0] f, input logic [DW-1:0] d);
        if (f == 3'b010) begin
            for (int b = 0; b < 4; b++) ref_mem[int'(a[5:2]) * 4 + b] = d[8*b +: 8];
        end else begin
            ref_mem[int'(a[5:0])] = d[7:0];
        end
    endtask

    function automatic req_t mk(input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic [2:0] funct);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.funct = funct;
        return r;
    endfunction

    task automatic driveBus();
        bus.req_valid  = {pres[1], pres[0]};
        bus.req_we     = {cur[1].we, cur[0].we};
        bus.req_addr0  = cur[0].addr;
        bus.req_addr1  = cur[1].addr;
        bus.req_wdata0 = cur[0].wdata;
        bus.req_wdata1 = cur[1].wdata;
        bus.req_funct0 = cur[0].funct;
        bus.req_funct1 = cur[1].funct;
    endtask

    // One clock: present queued requests, check the grant at negedge, record acceptances.
    task automatic applyStimulus();
        logic [1:0] v;
        logic [1:0] eg;
        sb_t        e;
        if (!pres[0] && pq0.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
            cur[0] = pq0.pop_front(); pres[0] = 1'b1;
        end
        if (!pres[1] && pq1.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
            cur[1] = pq1.pop_front(); pres[1] = 1'b1;
        end
        driveBus();
        @(negedge clk);
        v = {pres[1], pres[0]};
        if (reset) eg = 2'b00;
`ifdef DMEM_ARB_RR_EN
        else if (v == 2'b11) eg = exp_last ? 2'b01 : 2'b10;
`else
        else if (v == 2'b11) eg = 2'b01;
`endif
        else eg = v;
        if (reset) exp_last = 1'b1;
        else if (eg != 2'b00) exp_last = eg[1];
        checkOutput("req_ready", bus.req_ready, eg);
        for (int p = 0; p < 2; p++) begin
            if (bus.req_ready[p] && pres[p]) begin
                e.r = cur[p]; e.port = p; e.acc = cyc;
                sb.push_back(e);
                pres[p] = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    function automatic bit idle();
        return pq0.size() == 0 && pq1.size() == 0 && !pres[0] && !pres[1] && sb.size() == 0;
    endfunction

    task automatic runPhase(input string name, input int maxc);
        int n;
        n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!idle() && n < maxc);
        checkOutput({"done_", name}, 64'(idle()), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        checkOutput({tag, "_rsp_err"}, bus.rsp_err, 0);
        checkOutput({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        checkOutput({tag, "_mem_wr_en"}, mem_wr_en, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_wr_data"}, mem_wr_data, 0);
        checkOutput({tag, "_mem_funct"}, mem_funct, 0);
        checkOutput({tag, "_mem_funct7"}, mem_funct7, 0);
    endtask

    // Monitor: pops the oldest accepted command for every response pulse.
    initial begin : monitor
        sb_t           e;
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        forever begin
            @(negedge clk);
            if (reset) checkOutput("wr_en_in_reset", mem_wr_en, 0);
            else if (mem_wr_en) wr_seen++;
            if (bus.rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_rsp", bus.rsp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    exp_err = ref_illegal(e.r.funct, e.r.addr);
                    exp_rd  = '0;
                    if (!exp_err) begin
                        if (e.r.we) begin
                            ref_write(e.r.addr, e.r.funct, e.r.wdata);
                            wr_exp++;
                        end else begin
                            exp_rd = ref_read(e.r.addr, e.r.funct);
                        end
                    end
                    checkOutput("rsp_port", bus.rsp_valid, (e.port == 1) ? 2'b10 : 2'b01);
                    checkOutput("rsp_err", bus.rsp_err, exp_err);
                    checkOutput("rsp_rdata", bus.rsp_rdata, exp_rd);
                    checkOutput("rsp_latency", cyc - e.acc, 2);
                end
            end
            if (reset) sb.delete();
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin : stimulus
        int         w0;
        logic [7:0] rb;
        int         fsel;
        logic [2:0] f;
        logic [AW-1:0] a;
        for (int i = 0; i < MEM_BYTES; i++) begin
            rb = 8'($urandom);
            phys_mem[i] = rb;
            ref_mem[i]  = rb;
        end
        {phys_mem[19], phys_mem[18], phys_mem[17], phys_mem[16]} = 32'hDEADBEEF;
        {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]}     = 32'hDEADBEEF;
        pres[0] = 1'b0; pres[1] = 1'b0;
        cur[0] = '0; cur[1] = '0;
        driveBus();

        reset = 1'b1;
        applyStimulus();
        checkResetState("reset");
        pq0.push_back(mk(1'b0, 32'h10, 32'h0, 3'b010));
        applyStimulus();
        reset = 1'b0;
        runPhase("single_load", 20);

        w0 = wr_seen;
        pq1.push_back(mk(1'b1, 32'h13, 32'h0000_00A5, 3'b000));
        pq1.push_back(mk(1'b0, 32'h13, 32'h0, 3'b000));
        runPhase("byte_store_load", 20);
        checkOutput("byte_store_pulses", wr_seen - w0, 1);

        for (int i = 0; i < 4; i++) begin
            pq0.push_back(mk(1'b0, AW'(4 * i), 32'h0, 3'b010));
            pq1.push_back(mk(1'b0, AW'(32 + 4 * i), 32'h0, 3'b010));
        end
        runPhase("contention", 30);

        w0 = wr_seen;
        pq0.push_back(mk(1'b1, 32'h02, 32'hCAFE_F00D, 3'b010));
        pq1.push_back(mk(1'b1, 32'h08, 32'h1234_5678, 3'b001));
        pq1.push_back(mk(1'b0, 32'h0C, 32'h0, 3'b001));
        runPhase("illegal", 20);
        checkOutput("illegal_pulses", wr_seen - w0, 0);

        gap_pct = 30;
        for (int i = 0; i < 150; i++) begin
            for (int p = 0; p < 2; p++) begin
                fsel = int'($urandom_range(9));
                if (fsel < 4) f = 3'b000;
                else if (fsel < 9) f = 3'b010;
                else f = 3'($urandom_range(1, 7)) | 3'b001;
                a = AW'($urandom_range(MEM_BYTES - 1));
                if (f == 3'b010 && $urandom_range(9) != 0) a[1:0] = 2'b00;
                if (p == 0) pq0.push_back(mk(1'($urandom_range(1)), a, $urandom, f));
                else        pq1.push_back(mk(1'($urandom_range(1)), a, $urandom, f));
            end
        end
        runPhase("random", 2000);

        gap_pct = 0;
        pq1.push_back(mk(1'b1, 32'h20, ~ref_read(32'h20, 3'b010), 3'b010));
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        checkResetState("midflight");
        checkOutput("midflight_ready", bus.req_ready, 0);
        pq0.push_back(mk(1'b0, 32'h20, 32'h0, 3'b010));
        runPhase("after_reset", 20);

        for (int i = 0; i < MEM_BYTES; i++) begin
            checkOutput($sformatf("mem_byte_%0d", i), phys_mem[i], ref_mem[i]);
        end
        checkOutput("write_count", wr_seen, wr_exp);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
